// File: rtl/clock_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// Divisor type, config FSM states and fabric clock period.
package clock_sched_pkg;

  localparam int MasterPeriodNs = 8;
  localparam int DefDivWidth    = 16;

  typedef logic [DefDivWidth-1:0] divisor_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLIED
  } cfg_state_e;

endpackage

// File: rtl/tick_counter.sv
// One tick channel: divisor register, period counter and registered tick.
// A load or sync restarts the period from count 0.
module tick_counter
  import clock_sched_pkg::*;
#(
  parameter int DivWidth       = DefDivWidth,
  parameter int DefaultDivisor = 0
) (
  input  logic                MasterClock,
  input  logic                Reset,
  input  logic                LoadEn,
  input  logic [DivWidth-1:0] LoadDiv,
  input  logic                Sync,
  output logic [DivWidth-1:0] Div,
  output logic                Tick,
  output logic                AtBoundary
);

  localparam logic [DivWidth-1:0] ResetDiv = DivWidth'(DefaultDivisor);
  localparam logic [DivWidth-1:0] One      = DivWidth'(1);

  logic [DivWidth-1:0] count;
  logic                divZero;
  logic                lastCount;
  logic                terminal;

  assign divZero   = (Div == '0);
  assign lastCount = (count == (Div - One));
  assign terminal  = !divZero && lastCount && !Sync;
  assign AtBoundary = divZero || lastCount || Sync;

  // Divisor load, period counting and the tick one cycle after terminal count
  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      Div   <= ResetDiv;
      count <= '0;
      Tick  <= 1'b0;
    end else begin
      Tick <= terminal;
      if (LoadEn) begin
        Div <= LoadDiv;
      end
      if (Sync || LoadEn || terminal || divZero) begin
        count <= '0;
      end else begin
        count <= count + One;
      end
    end
  end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Multi-channel clock-enable generator with a valid/ready divisor config port.
// Define CLOCK_SCHED_SYNC_EN to add the SyncPulse phase-alignment input.
module clock_enable_scheduler
  import clock_sched_pkg::*;
#(
  parameter int NumChannels    = 4,
  parameter int DivWidth       = DefDivWidth,
  parameter int DefaultDivisor = 0,
  localparam int ChanWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic                   CfgValid,
  output logic                   CfgReady,
  input  logic [ChanWidth-1:0]   CfgChannel,
  input  logic [DivWidth-1:0]    CfgDivisor,
  output logic                   CfgApplied,
`ifdef CLOCK_SCHED_SYNC_EN
  input  logic                   SyncPulse,
`endif
  output logic [NumChannels-1:0] ChannelTick,
  output logic [NumChannels-1:0] ChannelActive
);

  localparam logic [ChanWidth:0] NumCh = (ChanWidth + 1)'(NumChannels);

  cfg_state_e state;
  cfg_state_e nextState;

  logic [ChanWidth-1:0] pendCh;
  logic [DivWidth-1:0]  pendDiv;
  logic                 accept;
  logic                 inRange;
  logic                 syncIn;
  logic                 pendBoundary;

  logic [NumChannels-1:0]               bnd;
  logic [NumChannels-1:0]               loadVec;
  logic [NumChannels-1:0][DivWidth-1:0] chDiv;

`ifdef CLOCK_SCHED_SYNC_EN
  assign syncIn = SyncPulse;
`else
  assign syncIn = 1'b0;
`endif

  assign accept       = CfgValid && (state == IDLE);
  assign inRange      = ({1'b0, CfgChannel} < NumCh);
  assign pendBoundary = bnd[pendCh];

  // Config state register
  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Capture the accepted in-range request
  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      pendCh  <= '0;
      pendDiv <= '0;
    end else if (accept && inRange) begin
      pendCh  <= CfgChannel;
      pendDiv <= CfgDivisor;
    end
  end

  // Next state: out-of-range requests are swallowed in IDLE
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept && inRange) nextState = PENDING;
      PENDING: if (pendBoundary) nextState = APPLIED;
      APPLIED: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs and the one-hot load strobe for the pending channel
  always_comb begin
    CfgReady   = (state == IDLE);
    CfgApplied = (state == APPLIED);
    loadVec    = '0;
    if (state == PENDING && pendBoundary) begin
      loadVec[pendCh] = 1'b1;
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : gCh
    tick_counter #(
      .DivWidth       (DivWidth),
      .DefaultDivisor (DefaultDivisor)
    ) uCnt (
      .MasterClock (MasterClock),
      .Reset       (Reset),
      .LoadEn      (loadVec[g]),
      .LoadDiv     (pendDiv),
      .Sync        (syncIn),
      .Div         (chDiv[g]),
      .Tick        (ChannelTick[g]),
      .AtBoundary  (bnd[g])
    );
    assign ChannelActive[g] = (chDiv[g] != '0);
  end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed bench for clock_enable_scheduler (4 channels, plus a 5-channel
// instance whose 3-bit channel field can address a nonexistent channel 7).
module tb_clock_enable_scheduler;

  logic        MasterClock = 1'b0;
  logic        Reset       = 1'b1;
  logic        CfgValid    = 1'b0;
  logic        CfgReady;
  logic [1:0]  CfgChannel  = '0;
  logic [15:0] CfgDivisor  = '0;
  logic        CfgApplied;
  logic        SyncPulse   = 1'b0;
  logic [3:0]  ChannelTick;
  logic [3:0]  ChannelActive;

  logic        CfgValid5   = 1'b0;
  logic        CfgReady5;
  logic [2:0]  CfgChannel5 = '0;
  logic [15:0] CfgDivisor5 = '0;
  logic        CfgApplied5;
  logic [4:0]  ChannelTick5;
  logic [4:0]  ChannelActive5;

  int checks = 0;
  int errors = 0;

  always #4 MasterClock = ~MasterClock;

  clock_enable_scheduler #(
    .NumChannels(4), .DivWidth(16), .DefaultDivisor(0)
  ) dut (
    .MasterClock   (MasterClock),
    .Reset         (Reset),
    .CfgValid      (CfgValid),
    .CfgReady      (CfgReady),
    .CfgChannel    (CfgChannel),
    .CfgDivisor    (CfgDivisor),
    .CfgApplied    (CfgApplied),
`ifdef CLOCK_SCHED_SYNC_EN
    .SyncPulse     (SyncPulse),
`endif
    .ChannelTick   (ChannelTick),
    .ChannelActive (ChannelActive)
  );

  clock_enable_scheduler #(
    .NumChannels(5), .DivWidth(16), .DefaultDivisor(0)
  ) dut5 (
    .MasterClock   (MasterClock),
    .Reset         (Reset),
    .CfgValid      (CfgValid5),
    .CfgReady      (CfgReady5),
    .CfgChannel    (CfgChannel5),
    .CfgDivisor    (CfgDivisor5),
    .CfgApplied    (CfgApplied5),
`ifdef CLOCK_SCHED_SYNC_EN
    .SyncPulse     (1'b0),
`endif
    .ChannelTick   (ChannelTick5),
    .ChannelActive (ChannelActive5)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        ready;
    logic        applied;
    logic [3:0]  tick;
    logic [3:0]  active;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge MasterClock);
    #1;
  endtask

  // Issue one request on the 4-channel DUT and wait for its CfgApplied,
  // then one more cycle so the port is back in IDLE.
  task automatic doCfg(input logic [1:0] ch, input logic [15:0] dv,
                       input int budget);
    logic seen;
    seen       = 1'b0;
    CfgValid   = 1'b1;
    CfgChannel = ch;
    CfgDivisor = dv;
    cyc();
    CfgValid = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (CfgApplied) seen = 1'b1;
    end
    chk("cfg_applied_wait", 32'(seen), 32'd1);
    cyc();
  endtask

  initial begin
    logic okTick, okAct, okApp, okRdy;
    logic [2:0] expv;

    // Test 2 trace: accept at row 0, apply seen at row 1, ticks every 5.
    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{valid: 1'b0, ch: 2'd0, div: 16'd0, ready: 1'b1,
                 applied: 1'b0, tick: 4'b0000, active: 4'b0001};
    end
    tbl[0]  = '{valid: 1'b1, ch: 2'd0, div: 16'd5, ready: 1'b0,
                applied: 1'b0, tick: 4'b0000, active: 4'b0000};
    tbl[1].ready   = 1'b0;
    tbl[1].applied = 1'b1;
    tbl[6].tick    = 4'b0001;
    tbl[11].tick   = 4'b0001;
    tbl[16].tick   = 4'b0001;

    // Reset values while reset held
    repeat (3) @(posedge MasterClock);
    #1;
    chk("rst_tick",    32'(ChannelTick),   32'h0);
    chk("rst_active",  32'(ChannelActive), 32'h0);
    chk("rst_ready",   32'(CfgReady),      32'h1);
    chk("rst_applied", 32'(CfgApplied),    32'h0);
    Reset = 1'b0;

    // Test 1: idle for 100 cycles
    okTick = 1'b1; okAct = 1'b1; okRdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ChannelTick != 4'h0) okTick = 1'b0;
      if (ChannelActive != 4'h0) okAct = 1'b0;
      if (CfgReady != 1'b1) okRdy = 1'b0;
    end
    chk("idle_tick",   32'(okTick), 32'd1);
    chk("idle_active", 32'(okAct),  32'd1);
    chk("idle_ready",  32'(okRdy),  32'd1);

    // Test 4: channel 7 on the 5-channel instance is dropped
    CfgValid5   = 1'b1;
    CfgChannel5 = 3'd7;
    CfgDivisor5 = 16'd9;
    cyc();
    CfgValid5 = 1'b0;
    chk("oor_ready_next", 32'(CfgReady5), 32'd1);
    okApp = 1'b1; okAct = 1'b1; okTick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (CfgApplied5) okApp = 1'b0;
      if (ChannelActive5 != 5'h0) okAct = 1'b0;
      if (ChannelTick5 != 5'h0) okTick = 1'b0;
      cyc();
    end
    chk("oor_no_applied", 32'(okApp),  32'd1);
    chk("oor_no_active",  32'(okAct),  32'd1);
    chk("oor_no_tick",    32'(okTick), 32'd1);

    // Test 2: table-driven ch0 div=5
    for (int i = 0; i < 17; i++) begin
      CfgValid   = tbl[i].valid;
      CfgChannel = tbl[i].ch;
      CfgDivisor = tbl[i].div;
      cyc();
      chk($sformatf("t2_ready[%0d]", i),   32'(CfgReady),      32'(tbl[i].ready));
      chk($sformatf("t2_applied[%0d]", i), 32'(CfgApplied),    32'(tbl[i].applied));
      chk($sformatf("t2_tick[%0d]", i),    32'(ChannelTick),   32'(tbl[i].tick));
      chk($sformatf("t2_active[%0d]", i),  32'(ChannelActive), 32'(tbl[i].active));
    end
    CfgValid = 1'b0;

    // Test 3: ch1 div=10, retarget to 3 when count==4
    for (int k = 0; k <= 18; k++) begin
      CfgValid   = (k == 0) || (k == 6);
      CfgChannel = 2'd1;
      CfgDivisor = (k == 0) ? 16'd10 : 16'd3;
      cyc();
      expv[2] = !((k <= 1) || (k >= 6 && k <= 11));
      expv[1] = (k == 1) || (k == 11);
      expv[0] = (k == 11) || (k == 14) || (k == 17);
      chk($sformatf("t3_rdy_app_tick[%0d]", k),
          32'({CfgReady, CfgApplied, ChannelTick[1]}), 32'(expv));
    end
    CfgValid = 1'b0;
    chk("t3_active", 32'(ChannelActive), 32'h3);

    // Test 5: reset while ch2 request is pending
    doCfg(2'd2, 16'd1000, 10);
    CfgValid   = 1'b1;
    CfgChannel = 2'd2;
    CfgDivisor = 16'd7;
    cyc();
    CfgValid = 1'b0;
    chk("t5_pending_ready", 32'(CfgReady), 32'd0);
    repeat (20) cyc();
    chk("t5_still_pending", 32'(CfgReady), 32'd0);
    #1;
    Reset = 1'b1;
    #1;
    chk("t5_rst_tick",    32'(ChannelTick),   32'h0);
    chk("t5_rst_active",  32'(ChannelActive), 32'h0);
    chk("t5_rst_ready",   32'(CfgReady),      32'h1);
    chk("t5_rst_applied", 32'(CfgApplied),    32'h0);
    repeat (2) cyc();
    Reset = 1'b0;
    okApp = 1'b1; okAct = 1'b1; okTick = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      cyc();
      if (CfgApplied) okApp = 1'b0;
      if (ChannelActive != 4'h0) okAct = 1'b0;
      if (ChannelTick != 4'h0) okTick = 1'b0;
    end
    chk("t5_no_applied", 32'(okApp),  32'd1);
    chk("t5_no_active",  32'(okAct),  32'd1);
    chk("t5_no_tick",    32'(okTick), 32'd1);

`ifdef CLOCK_SCHED_SYNC_EN
    // Test 6: SyncPulse aligns ch0 (div 4) and ch1 (div 6)
    doCfg(2'd0, 16'd4, 10);
    doCfg(2'd1, 16'd6, 10);
    repeat (7) cyc();
    SyncPulse = 1'b1;
    cyc();
    SyncPulse = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) cyc();
      chk($sformatf("t6_tick[%0d]", k), 32'(ChannelTick[1:0]),
          32'({(k == 6) || (k == 12), (k % 4 == 0) && (k != 0)}));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
